// File: rtl/riscv_pkg.sv
// Shared definitions for the write-back path of the integer register file.
// Holds the requester indices, the requester count and the write request
// record (destination register + data) used by riscv_regs_wb_arb.
package riscv_pkg;

  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_LSU    = 1;
  localparam int unsigned NUM_WB_REQ = 2;

  localparam int unsigned WB_ADDR_LENGTH = 5;
  localparam int unsigned WB_WORD_LENGTH = 32;

  typedef struct packed {
    logic [WB_ADDR_LENGTH-1:0] addr;
    logic [WB_WORD_LENGTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : per-requester request (bit 0 ALU, bit 1 LSU)
//   advance    : a grant was consumed this cycle; move the pointer to the winner
//   grant      : one-hot (or zero) grant, combinational from valid and rr_last
// rr_last resets to 1 so requester 0 wins the first tie.
module riscv_rr_arb2
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_WB_REQ-1:0] valid,
  input  logic                  advance,
  output logic [NUM_WB_REQ-1:0] grant
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: favour whoever did not win last time.
      2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (advance) begin
      rr_last_d = grant[REQ_LSU];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/riscv_regs_wb_arb.sv
// Write-back arbiter and sequencer for the register file's single write port.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid / req_ready        : per-requester handshake (bit 0 ALU, bit 1 LSU)
//   req_addr0/1, req_data0/1     : destination register and data per requester
//   rf_write_en/addr, rf_data    : registered write to the register file
//   rd_addr1/2, rf_read_data1/2  : read addresses and raw register file data
//   rd_data1/2                   : read data for consumers
// Build option: RISCV_WB_BYPASS_EN forwards the write currently on the port to
// matching read ports; otherwise the read data passes straight through.
module riscv_regs_wb_arb
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WB_WORD_LENGTH,
  parameter int unsigned ADDR_LENGTH = WB_ADDR_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WB_REQ-1:0]  req_valid,
  output logic [NUM_WB_REQ-1:0]  req_ready,
  input  logic [ADDR_LENGTH-1:0] req_addr0,
  input  logic [ADDR_LENGTH-1:0] req_addr1,
  input  logic [WORD_LENGTH-1:0] req_data0,
  input  logic [WORD_LENGTH-1:0] req_data1,
  output logic                   rf_write_en,
  output logic [ADDR_LENGTH-1:0] rf_write_addr,
  output logic [WORD_LENGTH-1:0] rf_data,
  input  logic [ADDR_LENGTH-1:0] rd_addr1,
  input  logic [ADDR_LENGTH-1:0] rd_addr2,
  input  logic [WORD_LENGTH-1:0] rf_read_data1,
  input  logic [WORD_LENGTH-1:0] rf_read_data2,
  output logic [WORD_LENGTH-1:0] rd_data1,
  output logic [WORD_LENGTH-1:0] rd_data2
);

  logic [NUM_WB_REQ-1:0]  grant;
  logic                   transfer;
  wb_req_t                req_alu, req_lsu, req_sel;

  logic                   rf_write_en_q, rf_write_en_d;
  logic [ADDR_LENGTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [WORD_LENGTH-1:0] rf_data_q, rf_data_d;

  riscv_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (transfer),
    .grant   (grant)
  );

  // No grant may be visible while reset is held.
  assign req_ready = grant & {NUM_WB_REQ{rst_n}};
  assign transfer  = |(req_valid & req_ready);

  assign req_alu = '{addr: req_addr0, data: req_data0};
  assign req_lsu = '{addr: req_addr1, data: req_data1};
  assign req_sel = grant[REQ_LSU] ? req_lsu : req_alu;

  always_comb begin
    rf_write_en_d   = 1'b0;
    rf_write_addr_d = rf_write_addr_q;
    rf_data_d       = rf_data_q;
    if (transfer) begin
      // x0 writes are consumed but never reach the register file.
      rf_write_en_d   = (req_sel.addr != '0);
      rf_write_addr_d = req_sel.addr;
      rf_data_d       = req_sel.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_en_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_data_q       <= '0;
    end else begin
      rf_write_en_q   <= rf_write_en_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_data_q       <= rf_data_d;
    end
  end

  assign rf_write_en   = rf_write_en_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_data       = rf_data_q;

`ifdef RISCV_WB_BYPASS_EN
  // Covers the cycle where the write is on the port but not yet committed.
  always_comb begin
    rd_data1 = rf_read_data1;
    rd_data2 = rf_read_data2;
    if (rf_write_en_q && (rd_addr1 == rf_write_addr_q) && (rd_addr1 != '0)) begin
      rd_data1 = rf_data_q;
    end
    if (rf_write_en_q && (rd_addr2 == rf_write_addr_q) && (rd_addr2 != '0)) begin
      rd_data2 = rf_data_q;
    end
  end
`else
  assign rd_data1 = rf_read_data1;
  assign rd_data2 = rf_read_data2;
`endif

endmodule

// File: tb/tb_riscv_regs_wb_arb.sv
module tb_riscv_regs_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  req_addr0, req_addr1;
  logic [31:0] req_data0, req_data1;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rf_read_data1, rf_read_data2, rd_data1, rd_data2;

  always #5 clk = ~clk;

  riscv_regs_wb_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_data       (rf_data),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  // Reference model: who won last, and what the write port should show.
  int          last_win;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Read-side stimulus applied together with the next drive.
  logic [4:0]  nxt_ra1 = '0, nxt_ra2 = '0;
  logic [31:0] nxt_rd1 = '0, nxt_rd2 = '0;
  logic [1:0]  seen_ready;
  logic [1:0]  tie_seq[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byp(input logic [4:0] ra, input logic [31:0] raw,
                                      input exp_t e);
`ifdef RISCV_WB_BYPASS_EN
    if (e.en && ra == e.addr && ra != 5'd0) return e.data;
`endif
    return raw;
  endfunction

  function automatic void model_reset();
    last_win = 1;
    m_en     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endfunction

  // One cycle of stimulus: apply at negedge, check the grant, queue the write
  // the port should show after the coming rising edge.
  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    int win;
    @(negedge clk);
    req_valid     = v;
    req_addr0     = a0;
    req_data0     = d0;
    req_addr1     = a1;
    req_data1     = d1;
    rd_addr1      = nxt_ra1;
    rd_addr2      = nxt_ra2;
    rf_read_data1 = nxt_rd1;
    rf_read_data2 = nxt_rd2;
    #1;
    if (v == 2'b11)  win = 1 - last_win;
    else if (v[0])   win = 0;
    else if (v[1])   win = 1;
    else             win = -1;
    seen_ready = req_ready;
    chk("req_ready", {30'd0, req_ready}, (win < 0) ? 32'd0 : (32'd1 << win));
    if (win >= 0) begin
      last_win = win;
      m_addr   = (win == 1) ? a1 : a0;
      m_data   = (win == 1) ? d1 : d0;
      m_en     = (m_addr != 5'd0);
    end else begin
      m_en = 1'b0;
    end
    q.push_back('{en: m_en, addr: m_addr, data: m_data});
  endtask

  // Monitor: compares the write port and read data after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (mon_en && q.size() > 0) begin
      e = q.pop_front();
      chk("rf_write_en", {31'd0, rf_write_en}, {31'd0, e.en});
      chk("rf_write_addr", {27'd0, rf_write_addr}, {27'd0, e.addr});
      chk("rf_data", rf_data, e.data);
      chk("rd_data1", rd_data1, byp(rd_addr1, rf_read_data1, e));
      chk("rd_data2", rd_data2, byp(rd_addr2, rf_read_data2, e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    model_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_addr0 = 5'd3; req_addr1 = 5'd4; req_data0 = '0; req_data1 = '0;
    rd_addr1 = '0; rd_addr2 = '0; rf_read_data1 = '0; rf_read_data2 = '0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_en", {31'd0, rf_write_en}, 32'd0);
    chk("rst_addr", {27'd0, rf_write_addr}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    mon_en = 1'b1;

    // Continuous ties from reset alternate starting with ALU.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 5'd1, 32'h100 + i, 5'd2, 32'h200 + i);
      tie_seq[i] = seen_ready;
    end
    chk("tie0", {30'd0, tie_seq[0]}, 32'd1);
    chk("tie1", {30'd0, tie_seq[1]}, 32'd2);
    chk("tie2", {30'd0, tie_seq[2]}, 32'd1);
    chk("tie3", {30'd0, tie_seq[3]}, 32'd2);

    // Lone ALU write x5.
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    chk("x5_ready", {30'd0, seen_ready}, 32'd1);
    @(posedge clk); #3;
    chk("x5_en", {31'd0, rf_write_en}, 32'd1);
    chk("x5_addr", {27'd0, rf_write_addr}, 32'd5);
    chk("x5_data", rf_data, 32'hDEADBEEF);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(posedge clk); #3;
    chk("x5_en_after", {31'd0, rf_write_en}, 32'd0);

    // LSU write to x0 is consumed but not written; next tie goes to ALU.
    drive(2'b10, 5'd0, 32'd0, 5'd0, 32'h1234);
    chk("x0_ready", {30'd0, seen_ready}, 32'd2);
    @(posedge clk); #3;
    chk("x0_en", {31'd0, rf_write_en}, 32'd0);
    drive(2'b11, 5'd6, 32'h66, 5'd8, 32'h88);
    chk("x0_next_tie", {30'd0, seen_ready}, 32'd1);

    // Read of the register being written in the N+1 window.
    nxt_ra1 = 5'd7; nxt_rd1 = 32'd0;
    drive(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'd0);
    @(posedge clk); #3;
`ifdef RISCV_WB_BYPASS_EN
    chk("byp_x7", rd_data1, 32'hA5A5A5A5);
`else
    chk("byp_x7", rd_data1, 32'd0);
`endif
    nxt_ra1 = 5'd0; nxt_rd1 = 32'h5555;
    drive(2'b01, 5'd0, 32'h77, 5'd0, 32'd0);
    @(posedge clk); #3;
    chk("byp_x0", rd_data1, 32'h5555);

    // Asynchronous reset while a write is on the port.
    drive(2'b01, 5'd9, 32'hCAFE0009, 5'd0, 32'd0);
    @(posedge clk); #3;
    chk("pre_rst_en", {31'd0, rf_write_en}, 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, rf_write_en}, 32'd0);
    chk("arst_addr", {27'd0, rf_write_addr}, 32'd0);
    chk("arst_data", rf_data, 32'd0);
    chk("arst_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(2'b11, 5'd10, 32'hA, 5'd11, 32'hB);
    chk("arst_ptr", {30'd0, seen_ready}, 32'd1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d0 = $urandom;
      d1 = $urandom;
      nxt_ra1 = ($urandom_range(0, 1) != 0) ? a0 : 5'($urandom_range(0, 31));
      nxt_ra2 = ($urandom_range(0, 1) != 0) ? a1 : 5'($urandom_range(0, 31));
      nxt_rd1 = $urandom;
      nxt_rd2 = $urandom;
      drive(v, a0, d0, a1, d1);
    end
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(posedge clk); #3;
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
